// File: rtl/console_rx_fifo.sv
// console_rx_fifo
// Receive-side buffer between the simpleuart console and the CPU's
// console-read instruction. A small drain FSM pulls every byte the UART has
// received into a circular FIFO; the CPU reads the FIFO head without
// blocking and sees 0 whenever nothing is pending.
//
// Ports:
//   clk, resetn        16 MHz clock, asynchronous active-low reset
//   uart_dat_do[31:0]  UART data register (all ones = no byte pending)
//   uart_dat_re        one-cycle acknowledge back to the UART
//   cpu_re             pop request (level, sampled every cycle)
//   cpu_do[31:0]       {24'b0, head} when non-empty, 0 when empty
//   rx_empty           FIFO empty
//   rx_count           bytes held, 0..2^DEPTH_LOG2
//   rx_ovf             sticky overflow flag
//   rx_drop_cnt[7:0]   saturating dropped-byte count
//   ovf_clr            clears rx_ovf and rx_drop_cnt
//
// Build option: define CONSOLE_RX_FIFO_OVF_EN to enable the overflow flag
// and drop counter; otherwise drops are silent and both outputs read 0.

module console_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           uart_dat_do,
  output logic                  uart_dat_re,
  input  logic                  cpu_re,
  output logic [31:0]           cpu_do,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_ovf,
  output logic [7:0]            rx_drop_cnt,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_SETTLE} state_t;

  state_t                  state_q, state_d;
  logic                    uart_re_q, uart_re_d;
  logic [7:0]              mem_q [DEPTH];
  logic [7:0]              mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;

  logic uart_avail, push_req, push_ok, pop_ok, full, drop;

  assign uart_avail = (uart_dat_do != 32'hFFFF_FFFF);
  assign full       = (count_q == CNT_FULL);
  // Pop needs data already present; a push into an empty FIFO cannot be
  // popped on the same edge.
  assign pop_ok     = cpu_re && (count_q != '0);
  assign push_req   = (state_q == S_IDLE) && uart_avail;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok    = push_req && (!full || pop_ok);
  assign drop       = push_req && !push_ok;

  // ---------------- drain FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- drain FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (uart_avail) state_d = S_ACK;
      S_ACK:    state_d = S_SETTLE;
      // UART needs this cycle to drop its valid before we look again.
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- drain FSM: outputs ----------------
  // Acknowledge is registered so it is high for exactly the ACK cycle.
  always_comb begin
    uart_re_d = 1'b0;
    if (state_q == S_IDLE && uart_avail) uart_re_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) uart_re_q <= 1'b0;
    else         uart_re_q <= uart_re_d;
  end

  assign uart_dat_re = uart_re_q;

  // ---------------- FIFO storage and pointers ----------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = uart_dat_do[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rx_count = count_q;
  assign rx_empty = (count_q == '0);
  assign cpu_do   = rx_empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q]};

  // ---------------- overflow reporting ----------------
`ifdef CONSOLE_RX_FIFO_OVF_EN
  logic       ovf_q, ovf_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A drop on the same edge as a clear wins and restarts the count at 1.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'h00;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)                  drop_cnt_d = 8'h01;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_ovf      = ovf_q;
  assign rx_drop_cnt = drop_cnt_q;
`else
  // Feature disabled: drops are silent and the clear input has no effect.
  logic unused_ovf;
  assign unused_ovf  = ^{ovf_clr, drop};
  assign rx_ovf      = 1'b0;
  assign rx_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_console_rx_fifo.sv
`timescale 1ns/1ps
module tb_console_rx_fifo;
  localparam int DL = 4;
`ifdef CONSOLE_RX_FIFO_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   uart_dat_do = 32'hFFFF_FFFF;
  logic          uart_dat_re;
  logic          cpu_re = 1'b0;
  logic [31:0]   cpu_do;
  logic          rx_empty;
  logic [DL:0]   rx_count;
  logic          rx_ovf;
  logic [7:0]    rx_drop_cnt;
  logic          ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [7:0] exp_q[$];

  always #31 clk = ~clk;

  console_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .resetn(resetn),
    .uart_dat_do(uart_dat_do), .uart_dat_re(uart_dat_re),
    .cpu_re(cpu_re), .cpu_do(cpu_do),
    .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_ovf(rx_ovf), .rx_drop_cnt(rx_drop_cnt),
    .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // UART model: the acknowledge clears the pending byte.
  always @(negedge clk) begin
    if (uart_dat_re === 1'b1) begin
      ack_cnt++;
      uart_dat_do = 32'hFFFF_FFFF;
    end
  end

  // Scoreboard monitor: every accepted pop must show the expected head.
  always @(negedge clk) begin
    if (resetn && cpu_re) begin
      if (rx_empty) chk("empty_read", cpu_do, 32'h0);
      else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop: got %h expected none", cpu_do);
      end else chk("pop_data", cpu_do, {24'h0, exp_q.pop_front()});
    end
  end

  // Present byte b in an IDLE cycle. pop_mode: 0 none, 1 cpu_re on the push
  // edge only, 2 cpu_re left high. clr asserts ovf_clr on the push edge.
  task automatic uart_send(input logic [7:0] b, input int pop_mode, input logic clr,
                           output logic [DL:0] cnt_ack);
    int n;
    int a0;
    @(posedge clk); #1;
    a0 = ack_cnt;
    uart_dat_do = {24'h0, b};
    if (pop_mode != 0) cpu_re = 1'b1;
    ovf_clr = clr;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (pop_mode == 1) cpu_re = 1'b0;
      ovf_clr = 1'b0;
    end while (uart_dat_re !== 1'b1 && n < 8);
    chk("ack_latency", 32'(n), 32'd1);
    cnt_ack = rx_count;
    @(posedge clk); #1;
    chk("ack_pulse_width", 32'(uart_dat_re), 32'd0);
    chk("ack_count", 32'(ack_cnt - a0), 32'd1);
  endtask

  task automatic pop_n(input int n);
    @(posedge clk); #1;
    cpu_re = 1'b1;
    repeat (n) @(posedge clk);
    #1 cpu_re = 1'b0;
  endtask

  initial begin
    logic [DL:0] c;
    int a0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_re", 32'(uart_dat_re), 32'd0);
    chk("rst_cpu_do", cpu_do, 32'h0);
    chk("rst_empty", 32'(rx_empty), 32'd1);
    chk("rst_count", 32'(rx_count), 32'd0);
    chk("rst_ovf", 32'(rx_ovf), 32'd0);
    chk("rst_drop", 32'(rx_drop_cnt), 32'd0);
    resetn = 1'b1;

    // Single byte then pop.
    exp_q.push_back(8'h41);
    uart_send(8'h41, 0, 1'b0, c);
    chk("cnt_at_ack_41", 32'(c), 32'd1);
    chk("cpu_do_41", cpu_do, 32'h41);
    pop_n(1);
    chk("after_pop_do", cpu_do, 32'h0);
    chk("after_pop_empty", 32'(rx_empty), 32'd1);

    // Reset while the acknowledge is high; byte must be drained once after.
    @(posedge clk); #1;
    a0 = ack_cnt;
    uart_dat_do = 32'h5A;
    @(posedge clk); #1;
    chk("mid_ack_re", 32'(uart_dat_re), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_re", 32'(uart_dat_re), 32'd0);
    chk("mid_rst_count", 32'(rx_count), 32'd0);
    chk("mid_rst_empty", 32'(rx_empty), 32'd1);
    chk("mid_rst_do", cpu_do, 32'h0);
    @(posedge clk); #1;
    chk("ack_in_reset", 32'(ack_cnt - a0), 32'd0);
    exp_q.push_back(8'h5A);
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_once", 32'(ack_cnt - a0), 32'd1);
    chk("drain_count", 32'(rx_count), 32'd1);
    pop_n(1);
    chk("drain_empty", 32'(rx_empty), 32'd1);

    // Fill 0x00..0x0F, then pop 17 (last one ignored) across pointer wrap.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      uart_send(8'(i), 0, 1'b0, c);
    end
    chk("full_count", 32'(rx_count), 32'd16);
    chk("full_head", cpu_do, 32'h0);
    pop_n(17);
    chk("drained_count", 32'(rx_count), 32'd0);
    chk("drained_empty", 32'(rx_empty), 32'd1);
    chk("sb_empty_1", 32'(exp_q.size()), 32'd0);

    // Refill, then drop 0x99.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      uart_send(8'(8'h20 + i), 0, 1'b0, c);
    end
    uart_send(8'h99, 0, 1'b0, c);
    chk("drop_cnt_at_ack", 32'(c), 32'd16);
    chk("drop_count", 32'(rx_count), 32'd16);
    chk("drop_ovf", 32'(rx_ovf), 32'(OVF));
    chk("drop_cnt", 32'(rx_drop_cnt), 32'(OVF));
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    chk("clr_ovf", 32'(rx_ovf), 32'd0);
    chk("clr_cnt", 32'(rx_drop_cnt), 32'd0);

    // Drop coinciding with clear: the drop wins.
    uart_send(8'hAA, 0, 1'b1, c);
    chk("drop_vs_clr_ovf", 32'(rx_ovf), 32'(OVF));
    chk("drop_vs_clr_cnt", 32'(rx_drop_cnt), 32'(OVF));
    chk("drop_vs_clr_count", 32'(rx_count), 32'd16);

    // Full FIFO, pop and push of 0x77 on the same edge: no drop.
    exp_q.push_back(8'h77);
    uart_send(8'h77, 1, 1'b0, c);
    chk("swap_cnt_at_ack", 32'(c), 32'd16);
    chk("swap_count", 32'(rx_count), 32'd16);
    chk("swap_no_drop", 32'(rx_drop_cnt), 32'(OVF));
    pop_n(16);
    chk("sb_empty_2", 32'(exp_q.size()), 32'd0);
    chk("swap_empty", 32'(rx_empty), 32'd1);

    // Empty FIFO with cpu_re held while 0x33 arrives.
    exp_q.push_back(8'h33);
    uart_send(8'h33, 2, 1'b0, c);
    chk("hold_cnt_at_ack", 32'(c), 32'd1);
    cpu_re = 1'b0;
    chk("hold_count", 32'(rx_count), 32'd0);
    chk("sb_empty_3", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/console_rx_fifo.md
# console_rx_fifo

Receive-side buffer between the `simpleuart` console and the CPU's console-read instruction (`B3`). Autonomously drains each byte the UART has received into a small circular FIFO and presents the FIFO head to the CPU. The CPU keeps its existing non-blocking semantics: it reads 0 when nothing is pending. This lets the CPU sit in long `DELAY` loops without losing characters at 300 baud.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 bytes (16 by default).

Ports:
- `clk` in 1: 16 MHz system clock.
- `resetn` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `uart_dat_do` in 32: UART data register. Value 32'hFFFF_FFFF means no byte pending; any other value carries the byte in [7:0].
- `uart_dat_re` out 1: one-cycle acknowledge to the UART; clears its receive buffer.
- `cpu_re` in 1: pop request, level, sampled every cycle.
- `cpu_do` out 32: {24'b0, head byte} when non-empty, 32'h0 when empty. Combinational from FIFO state.
- `rx_empty` out 1: FIFO empty.
- `rx_count` out DEPTH_LOG2+1: number of bytes held, 0..2^DEPTH_LOG2.
- `rx_ovf` out 1: sticky overflow flag (see Configuration).
- `rx_drop_cnt` out 8: saturating count of dropped bytes (see Configuration).
- `ovf_clr` in 1: clears `rx_ovf` and `rx_drop_cnt`.

## Operation

- Storage: 2^DEPTH_LOG2 × 8 register array.
  - Write pointer and read pointer, each DEPTH_LOG2 bits, wrap modulo depth.
  - `rx_count` is tracked separately; full = count == 2^DEPTH_LOG2.
- Drain FSM, states IDLE, ACK, SETTLE:
  - IDLE: if `uart_dat_do` != 32'hFFFF_FFFF, capture [7:0] as a push candidate, register `uart_dat_re`<=1, go to ACK. Otherwise stay.
  - ACK: `uart_dat_re` is high for exactly this cycle; register it back to 0; go to SETTLE.
  - SETTLE: no action, because the UART needs this cycle to drop its valid. Go to IDLE.
  - Total: 3 cycles per byte minimum, far faster than any supported baud.
- Push: happens on the IDLE→ACK edge.
  - Accepted if count < depth, or if a pop is accepted in the same cycle.
  - Otherwise the byte is dropped (drop-newest). The UART is still acknowledged, so it never stalls.
- Pop: happens on a cycle where `cpu_re`=1 and count > 0.
  - Read pointer advances; `cpu_do` shows the next head from the following cycle.
  - `cpu_re` while empty is ignored and has no side effect.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - If the FIFO was empty, the pop is ignored and the push lands, so count becomes 1.
- Holding `cpu_re` high pops one byte per cycle until empty.
- Reset, including mid-transfer:
  - FSM→IDLE, pointers and count 0, `uart_dat_re`=0, `cpu_do`=0, `rx_empty`=1, `rx_ovf`=0, `rx_drop_cnt`=0.
  - A byte pending in the UART is re-seen and drained after reset is released.

## Timing

- UART byte present at cycle t (FSM in IDLE): `uart_dat_re` is high in cycle t+1; the byte is visible on `cpu_do` in cycle t+1; `rx_count` increments at the t+1 edge.
- Pop at edge e: `cpu_do` and `rx_count` update in the cycle after e. The CPU samples `cpu_do` in the same cycle it asserts `cpu_re`.
- `rx_empty`, `rx_count` and `cpu_do` are derived from registered state only; no input-to-output combinational path.
- `ovf_clr` takes effect at the next edge. If a drop coincides with `ovf_clr`, the drop wins: `rx_ovf`=1, `rx_drop_cnt`=1.

## Configuration

- `CONSOLE_RX_FIFO_OVF_EN` defined:
  - Each dropped byte sets `rx_ovf` and increments `rx_drop_cnt`, saturating at 255.
  - Both are cleared by `ovf_clr`.
- Not defined:
  - Drops are silent. `rx_ovf` and `rx_drop_cnt` are tied to 0 and `ovf_clr` is ignored.
  - Port list is identical in both builds.

## Test plan

- Reset mid-ACK (assert `resetn`=0 while `uart_dat_re`=1) -> all outputs return to reset values immediately; after release, the still-pending UART byte 0x5A is drained exactly once.
- UART presents 0x41, then 0xFFFF_FFFF -> `uart_dat_re` high for exactly 1 cycle; `cpu_do`=0x0000_0041, `rx_count`=1; pulse `cpu_re` -> `cpu_do`=0, `rx_empty`=1.
- Push bytes 0x00..0x0F with no pops (DEPTH_LOG2=4) -> `rx_count`=16; pop all 16 -> values return in order 0x00..0x0F across read-pointer wrap; a 17th `cpu_re` is ignored.
- Full FIFO, UART byte 0x99 arrives with no pop -> byte dropped, `uart_dat_re` still pulsed, count stays 16; with OVF_EN: `rx_ovf`=1, `rx_drop_cnt`=1; `ovf_clr` -> both 0.
- Full FIFO, `cpu_re` asserted on the same edge as the push of 0x77 -> count stays 16; 0x77 becomes the last entry; no drop.
- Empty FIFO, `cpu_re` held high on the same edge as the push of 0x33 -> count becomes 1 and `cpu_do`=0x33; popped on the next cycle.
